// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute/predictor-update bundle for branch_resolve_unit.
// The slave side is the resolve unit itself.
interface branch_resolve_unit_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             fetch_branch;
    logic [PC_W-1:0]  fetch_pc;
    logic             fetch_pred;
    logic             resolve_valid;
    logic             resolve_taken;
    logic [PC_W-1:0]  resolve_target;
    logic             full;
    logic             upd_we;
    logic [PC_W-1:0]  upd_pc;
    logic             upd_taken;
    logic             flush;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output fetch_branch, fetch_pc, fetch_pred,
        output resolve_valid, resolve_taken, resolve_target,
        input  full, upd_we, upd_pc, upd_taken, flush, redirect_pc,
        input  branch_count, mispredict_count
    );

    modport slave (
        input  fetch_branch, fetch_pc, fetch_pred,
        input  resolve_valid, resolve_taken, resolve_target,
        output full, upd_we, upd_pc, upd_taken, flush, redirect_pc,
        output branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order FIFO of predicted branches; each resolve drives a predictor update,
// and a mispredict flushes the pipeline and empties the FIFO.
module branch_resolve_unit #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic                 clk,
    input logic                 rst,
    branch_resolve_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [PC_W-1:0]  pc_mem_q   [DEPTH];
    logic [PC_W-1:0]  pc_mem_d   [DEPTH];
    logic             pred_mem_q [DEPTH];
    logic             pred_mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             upd_we_q, upd_we_d;
    logic [PC_W-1:0]  upd_pc_q, upd_pc_d;
    logic             upd_taken_q, upd_taken_d;
    logic             flush_q, flush_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    logic            full;
    logic            do_pop;
    logic            do_push;
    logic            mispredict;
    logic [PC_W-1:0] head_pc;
    logic            head_pred;

    assign full       = (count_q == (AW+1)'(DEPTH));
    assign head_pc    = pc_mem_q[rd_ptr_q];
    assign head_pred  = pred_mem_q[rd_ptr_q];
    assign do_pop     = bus.resolve_valid && (count_q != '0);
    assign mispredict = do_pop && (head_pred != bus.resolve_taken);
    // A pop frees a slot on the same edge, so a full queue still accepts a push;
    // a push alongside a mispredict is wrong-path and is dropped.
    assign do_push    = bus.fetch_branch && (!full || do_pop) && !mispredict;

    always_comb begin
        pc_mem_d           = pc_mem_q;
        pred_mem_d         = pred_mem_q;
        rd_ptr_d           = rd_ptr_q;
        wr_ptr_d           = wr_ptr_q;
        count_d            = count_q;
        upd_we_d           = 1'b0;
        upd_pc_d           = upd_pc_q;
        upd_taken_d        = upd_taken_q;
        flush_d            = 1'b0;
        redirect_pc_d      = redirect_pc_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;

        if (do_push) begin
            pc_mem_d[wr_ptr_q]   = bus.fetch_pc;
            pred_mem_d[wr_ptr_q] = bus.fetch_pred;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end

        if (do_pop) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            upd_we_d    = 1'b1;
            upd_pc_d    = head_pc;
            upd_taken_d = bus.resolve_taken;
            if (branch_count_q != '1)
                branch_count_d = branch_count_q + 1'b1;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (mispredict) begin
            flush_d       = 1'b1;
            redirect_pc_d = bus.resolve_taken ? bus.resolve_target : head_pc + 1'b1;
            if (mispredict_count_q != '1)
                mispredict_count_d = mispredict_count_q + 1'b1;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_mem_q           <= '{default: '0};
            pred_mem_q         <= '{default: 1'b0};
            rd_ptr_q           <= '0;
            wr_ptr_q           <= '0;
            count_q            <= '0;
            upd_we_q           <= 1'b0;
            upd_pc_q           <= '0;
            upd_taken_q        <= 1'b0;
            flush_q            <= 1'b0;
            redirect_pc_q      <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            pc_mem_q           <= pc_mem_d;
            pred_mem_q         <= pred_mem_d;
            rd_ptr_q           <= rd_ptr_d;
            wr_ptr_q           <= wr_ptr_d;
            count_q            <= count_d;
            upd_we_q           <= upd_we_d;
            upd_pc_q           <= upd_pc_d;
            upd_taken_q        <= upd_taken_d;
            flush_q            <= flush_d;
            redirect_pc_q      <= redirect_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign bus.full             = full;
    assign bus.upd_we           = upd_we_q;
    assign bus.upd_pc           = upd_pc_q;
    assign bus.upd_taken        = upd_taken_q;
    assign bus.flush            = flush_q;
    assign bus.redirect_pc      = redirect_pc_q;
    assign bus.branch_count     = branch_count_q;
    assign bus.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a reference queue model predicts
// each update/flush pulse, compared one cycle after the resolve is driven.
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.PC_W(10), .CNT_W(16)) bif ();
    branch_resolve_unit #(.PC_W(10), .DEPTH(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    // Narrow-counter instance so saturation is reachable in a few cycles.
    branch_resolve_unit_if #(.PC_W(4), .CNT_W(3)) sif ();
    branch_resolve_unit #(.PC_W(4), .DEPTH(2), .CNT_W(3)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    typedef struct {
        logic [9:0] pc;
        logic       pred;
    } ent_t;

    typedef struct {
        logic [9:0] pc;
        logic       taken;
        logic       flush;
        logic [9:0] redir;
    } exp_t;

    ent_t  mq[$];
    exp_t  expq[$];
    int    n_checks = 0;
    int    n_errors = 0;
    logic [15:0] m_bc = '0;
    logic [15:0] m_mc = '0;
    logic [9:0]  m_redir = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        expq.delete();
        m_bc    = '0;
        m_mc    = '0;
        m_redir = '0;
    endtask

    // Drive one cycle of stimulus, advance the model, then compare after the edge.
    task automatic step(input logic fb, input logic [9:0] fpc, input logic fpred,
                        input logic rv, input logic rt, input logic [9:0] tgt);
        bit   was_full;
        bit   pop;
        bit   mis;
        ent_t h;
        ent_t n;
        exp_t e;
        bif.fetch_branch   = fb;
        bif.fetch_pc       = fpc;
        bif.fetch_pred     = fpred;
        bif.resolve_valid  = rv;
        bif.resolve_taken  = rt;
        bif.resolve_target = tgt;

        was_full = (mq.size() == 4);
        pop      = rv && (mq.size() != 0);
        mis      = 1'b0;
        if (pop) begin
            h   = mq.pop_front();
            mis = (h.pred != rt);
            if (m_bc != 16'hFFFF) m_bc++;
            if (mis) begin
                if (m_mc != 16'hFFFF) m_mc++;
                m_redir = rt ? tgt : h.pc + 10'd1;
                mq.delete();
            end
            e.pc = h.pc; e.taken = rt; e.flush = mis; e.redir = m_redir;
            expq.push_back(e);
        end
        if (fb && (!was_full || pop) && !mis) begin
            n.pc = fpc; n.pred = fpred;
            mq.push_back(n);
        end

        @(posedge clk);
        #1;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            check_eq("upd_we", 32'(bif.upd_we), 32'd1);
            check_eq("upd_pc", 32'(bif.upd_pc), 32'(e.pc));
            check_eq("upd_taken", 32'(bif.upd_taken), 32'(e.taken));
            check_eq("flush", 32'(bif.flush), 32'(e.flush));
            check_eq("redirect_pc", 32'(bif.redirect_pc), 32'(e.redir));
        end else begin
            check_eq("upd_we_idle", 32'(bif.upd_we), 32'd0);
            check_eq("flush_idle", 32'(bif.flush), 32'd0);
        end
        check_eq("full", 32'(bif.full), 32'(mq.size() == 4));
        check_eq("branch_count", 32'(bif.branch_count), 32'(m_bc));
        check_eq("mispredict_count", 32'(bif.mispredict_count), 32'(m_mc));
    endtask

    task automatic idle();
        step(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000);
    endtask

    initial begin
        bif.fetch_branch = 1'b0; bif.fetch_pc = '0; bif.fetch_pred = 1'b0;
        bif.resolve_valid = 1'b0; bif.resolve_taken = 1'b0; bif.resolve_target = '0;
        sif.fetch_branch = 1'b0; sif.fetch_pc = '0; sif.fetch_pred = 1'b0;
        sif.resolve_valid = 1'b0; sif.resolve_taken = 1'b0; sif.resolve_target = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_upd_we", 32'(bif.upd_we), 32'd0);
        check_eq("rst_flush", 32'(bif.flush), 32'd0);
        check_eq("rst_full", 32'(bif.full), 32'd0);
        check_eq("rst_bc", 32'(bif.branch_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Correct prediction
        step(1'b1, 10'h010, 1'b1, 1'b0, 1'b0, 10'h000);
        step(1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h100);
        idle();

        // Mispredict, taken -> target
        step(1'b1, 10'h020, 1'b0, 1'b0, 1'b0, 10'h000);
        step(1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h3F0);
        idle();

        // Mispredict, not-taken -> pc+1, younger entries discarded, wrong-path push dropped
        step(1'b1, 10'h030, 1'b1, 1'b0, 1'b0, 10'h000);
        step(1'b1, 10'h031, 1'b1, 1'b0, 1'b0, 10'h000);
        step(1'b1, 10'h032, 1'b0, 1'b0, 1'b0, 10'h000);
        step(1'b1, 10'h033, 1'b1, 1'b1, 1'b0, 10'h000);
        step(1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h000);
        step(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000);

        // Offset pointers, fill, overflow, push+pop while full, drain
        step(1'b1, 10'h040, 1'b0, 1'b0, 1'b0, 10'h000);
        step(1'b1, 10'h041, 1'b1, 1'b1, 1'b0, 10'h000);
        step(1'b1, 10'h042, 1'b0, 1'b0, 1'b0, 10'h000);
        step(1'b1, 10'h043, 1'b1, 1'b0, 1'b0, 10'h000);
        step(1'b1, 10'h044, 1'b0, 1'b0, 1'b0, 10'h000);
        step(1'b1, 10'h045, 1'b1, 1'b0, 1'b0, 10'h000);
        step(1'b1, 10'h046, 1'b1, 1'b1, 1'b1, 10'h000);
        for (int i = 0; i < 5; i++) begin
            logic t;
            t = (mq.size() != 0) ? mq[0].pred : 1'b0;
            step(1'b0, 10'h000, 1'b0, 1'b1, t, 10'h000);
        end

        // Redirect wraps from all-ones to zero
        step(1'b1, 10'h3FF, 1'b1, 1'b0, 1'b0, 10'h000);
        step(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000);
        idle();

        // Asynchronous reset between edges with an update pulse live
        step(1'b1, 10'h050, 1'b1, 1'b0, 1'b0, 10'h000);
        step(1'b1, 10'h051, 1'b0, 1'b0, 1'b0, 10'h000);
        step(1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h000);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_upd_we", 32'(bif.upd_we), 32'd0);
        check_eq("arst_upd_pc", 32'(bif.upd_pc), 32'd0);
        check_eq("arst_upd_taken", 32'(bif.upd_taken), 32'd0);
        check_eq("arst_flush", 32'(bif.flush), 32'd0);
        check_eq("arst_redirect", 32'(bif.redirect_pc), 32'd0);
        check_eq("arst_bc", 32'(bif.branch_count), 32'd0);
        check_eq("arst_mc", 32'(bif.mispredict_count), 32'd0);
        check_eq("arst_full", 32'(bif.full), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000);
        step(1'b1, 10'h060, 1'b0, 1'b0, 1'b0, 10'h000);
        step(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000);
        idle();

        // Counter saturation on the narrow instance: ten mispredicts
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sif.fetch_branch = 1'b1; sif.fetch_pc = 4'(i); sif.fetch_pred = 1'b0;
            sif.resolve_valid = 1'b0;
            @(negedge clk);
            sif.fetch_branch = 1'b0;
            sif.resolve_valid = 1'b1; sif.resolve_taken = 1'b1; sif.resolve_target = 4'hA;
            if (i == 6) begin
                @(negedge clk);
                sif.resolve_valid = 1'b0;
                check_eq("sat_bc_7", 32'(sif.branch_count), 32'd7);
            end
        end
        @(negedge clk);
        sif.resolve_valid = 1'b0;
        check_eq("sat_bc", 32'(sif.branch_count), 32'd7);
        check_eq("sat_mc", 32'(sif.mispredict_count), 32'd7);
        check_eq("sat_redirect", 32'(sif.redirect_pc), 32'hA);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
